// File: rtl/fft_output_unloader_if.sv
// fft_output_unloader_if
//   Output stream bundle of the FFT frame unloader.
//   master : drives m_valid, m_real, m_imag, m_index, m_last; samples m_ready
//   slave  : samples the beat fields; drives m_ready
//   A beat transfers on a rising clock edge where m_valid && m_ready.
interface fft_output_unloader_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) ();
  logic                     m_valid;
  logic                     m_ready;
  logic signed [DATA_W-1:0] m_real;
  logic signed [DATA_W-1:0] m_imag;
  logic [ADDR_W-1:0]        m_index;
  logic                     m_last;

  modport master (
    output m_valid, m_real, m_imag, m_index, m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid, m_real, m_imag, m_index, m_last,
    output m_ready
  );
endinterface

// File: rtl/fft_output_unloader.sv
// fft_output_unloader
//   Drains one completed FFT frame (N = 2**ADDR_W complex samples) from a
//   dual-port RAM read port and streams it out on a valid/ready bus, one
//   sample per cycle while the sink keeps m_ready high.
//
// Ports
//   clk, rst      clock (rising edge), synchronous active-high reset
//   start         1-cycle pulse, begins a frame; ignored unless idle
//   busy          high while a frame is in progress
//   done          1-cycle pulse in the cycle after the last beat transfers
//   ram_addr      registered RAM read address
//   ram_dout_re/im RAM read data, valid one cycle after ram_addr
//   m             output stream (fft_output_unloader_if.master)
//
// Build option
//   FFT_UNLOAD_BITREV_EN : read addresses are the bit-reverse of the issue
//   count (frame stored in bit-reversed order). m_index stays natural order.
//
// States
//   state   | meaning
//   S_IDLE  | waiting for start
//   S_ISSUE | issuing reads, rd_cnt < N
//   S_DRAIN | all reads issued, waiting for the last beat to transfer
module fft_output_unloader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W-1:0]        ram_addr,
  input  logic signed [DATA_W-1:0] ram_dout_re,
  input  logic signed [DATA_W-1:0] ram_dout_im,
  fft_output_unloader_if.master    m
);

  localparam logic [ADDR_W:0]   LAST_RD  = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W:0]          rd_cnt;
  logic [ADDR_W-1:0]        issue_addr;
  logic                     a_v;       // ram_addr holds a live read this cycle
  logic                     d_v;       // ram_dout holds live data this cycle
  logic                     issue;
  logic                     pop;
  logic                     last_pop;
  logic                     done_set;
  logic [2:0]               pend;

  // Output storage. A read takes two edges to land here and a pop is only
  // seen one edge later, so sustained one-beat-per-cycle needs three slots
  // in the loop. With m_ready low the issue logic parks at two outstanding
  // entries; the third slot only covers a read launched while m_ready was
  // high and the sink stalls afterwards, so nothing is ever dropped.
  logic signed [DATA_W-1:0] buf_re [3];
  logic signed [DATA_W-1:0] buf_im [3];
  logic [1:0]               wr_ptr;
  logic [1:0]               rd_ptr;
  logic [1:0]               cnt;
  logic [ADDR_W-1:0]        out_idx;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign busy      = (state != S_IDLE);
  assign m.m_valid = (cnt != 2'd0);
  assign m.m_real  = buf_re[rd_ptr];
  assign m.m_imag  = buf_im[rd_ptr];
  assign m.m_index = out_idx;
  assign m.m_last  = m.m_valid && (out_idx == LAST_IDX);

  assign pop      = m.m_valid && m.m_ready;
  assign last_pop = pop && m.m_last;

  // Storage occupancy once this cycle's pop and all in-flight reads settle.
  assign pend = {1'b0, cnt} + {2'b00, a_v} + {2'b00, d_v} - {2'b00, pop};

  always_comb begin
    issue_addr = rd_cnt[ADDR_W-1:0];
`ifdef FFT_UNLOAD_BITREV_EN
    for (int i = 0; i < ADDR_W; i++) begin
      issue_addr[i] = rd_cnt[ADDR_W-1-i];
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    done_set  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if ((pend < 3'd2) || ((pend == 3'd2) && m.m_ready)) begin
          issue = 1'b1;
          if (rd_cnt == LAST_RD) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (last_pop) begin
          state_nxt = S_IDLE;
          done_set  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt   <= '0;
      ram_addr <= '0;
      a_v      <= 1'b0;
      d_v      <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= done_set;
      a_v  <= issue;
      d_v  <= a_v;
      if ((state == S_IDLE) && start) begin
        rd_cnt <= '0;
      end else if (issue) begin
        ram_addr <= issue_addr;
        rd_cnt   <= rd_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= 2'd0;
      rd_ptr  <= 2'd0;
      cnt     <= 2'd0;
      out_idx <= '0;
      for (int i = 0; i < 3; i++) begin
        buf_re[i] <= '0;
        buf_im[i] <= '0;
      end
    end else begin
      if (d_v) begin
        buf_re[wr_ptr] <= ram_dout_re;
        buf_im[wr_ptr] <= ram_dout_im;
        wr_ptr         <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr  <= ptr_inc(rd_ptr);
        // wraps N-1 -> 0 exactly on the final beat of the frame
        out_idx <= out_idx + 1'b1;
      end
      cnt <= cnt + {1'b0, d_v} - {1'b0, pop};
    end
  end

endmodule
